alu_unit: RTL and testbench

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/sap1_pkg.sv | 29 ++
 rtl/b_register.sv | 23 ++
 rtl/alu_unit.sv | 158 +++++++++++++++
 tb/tb_alu_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: datapath widths, multiply FSM states, add/sub helper.
package sap1_pkg;

  localparam int DATA_W    = 8;
  localparam int MUL_STEPS = 8;
  localparam int PROD_W    = 2 * DATA_W;
  localparam int CNT_W     = 4;

  localparam logic [CNT_W-1:0] MUL_COUNT_INIT = CNT_W'(MUL_STEPS);
  localparam logic [CNT_W-1:0] MUL_COUNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Two's-complement add/subtract; bit DATA_W is carry (no-borrow when subtracting).
  function automatic logic [DATA_W:0] add_sub(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              sub
  );
    logic [DATA_W-1:0] b_op;
    b_op = sub ? ~b : b;
    return {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub};
  endfunction

endpackage

// File: rtl/b_register.sv
// B operand register: loads from the W bus on an active-low load strobe.
module b_register
  import sap1_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Load or hold the operand; reset wins over load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= {DATA_W{1'b0}};
    end else if (!load_n) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// SAP-1 ALU: combinational add/sub onto the W bus, latched flags, and a
// shift-and-add 8x8 multiplier that runs alongside the adder.
module alu_unit
  import sap1_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a_in,
  inout  wire  [DATA_W-1:0] w_bus,
  input  logic              load_b_n,
  input  logic              sub,
  input  logic              eu,
  input  logic              sel_prod,
  input  logic              flag_en,
  input  logic              mul_start,
  output logic              busy,
  output logic              done,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              prod_ovf,
  output logic [DATA_W-1:0] b_out
);

  logic [DATA_W-1:0] w_b_q;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_result;
  logic              w_busy;
  logic              w_load_n;

  mul_state_t        r_state, w_state_nxt;
  logic [PROD_W-1:0] r_mcand, w_mcand_nxt;
  logic [PROD_W-1:0] r_acc, w_acc_nxt;
  logic [DATA_W-1:0] r_mplier, w_mplier_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [DATA_W-1:0] r_prod_q, w_prod_nxt;
  logic              r_prod_ovf, w_ovf_nxt;
  logic              r_done, w_done_nxt;
  logic              r_carry, r_zero;

  // B must not change under a running multiply, so loads are gated by busy.
  assign w_busy   = (r_state != IDLE);
  assign w_load_n = load_b_n | w_busy;

  b_register u_b_register (
    .clk    (clk),
    .reset  (reset),
    .load_n (w_load_n),
    .d      (w_bus),
    .q      (w_b_q)
  );

  assign w_sum = add_sub(a_in, w_b_q, sub);

  // Select what goes onto the bus: product register or adder result.
  always_comb begin
    if (sel_prod) begin
      w_result = r_prod_q;
    end else begin
      w_result = w_sum[DATA_W-1:0];
    end
  end

  assign w_bus = eu ? w_result : {DATA_W{1'bz}};

  // Flags latch only when asked; independent of the multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (flag_en) begin
      r_carry <= w_sum[DATA_W];
      r_zero  <= (w_sum[DATA_W-1:0] == {DATA_W{1'b0}});
    end else begin
      r_carry <= r_carry;
      r_zero  <= r_zero;
    end
  end

  // Multiply FSM next-state and datapath: capture operands, 8 shift-add steps, publish.
  always_comb begin
    w_state_nxt  = r_state;
    w_mcand_nxt  = r_mcand;
    w_acc_nxt    = r_acc;
    w_mplier_nxt = r_mplier;
    w_count_nxt  = r_count;
    w_prod_nxt   = r_prod_q;
    w_ovf_nxt    = r_prod_ovf;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (mul_start) begin
          w_state_nxt  = RUN;
          w_mcand_nxt  = {{DATA_W{1'b0}}, a_in};
          w_mplier_nxt = w_b_q;
          w_acc_nxt    = {PROD_W{1'b0}};
          w_count_nxt  = MUL_COUNT_INIT;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      RUN: begin
        if (r_mplier[0]) begin
          w_acc_nxt = r_acc + r_mcand;
        end else begin
          w_acc_nxt = r_acc;
        end
        w_mcand_nxt  = {r_mcand[PROD_W-2:0], 1'b0};
        w_mplier_nxt = {1'b0, r_mplier[DATA_W-1:1]};
        w_count_nxt  = r_count - MUL_COUNT_ONE;
        if (r_count == MUL_COUNT_ONE) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        w_prod_nxt  = r_acc[DATA_W-1:0];
        w_ovf_nxt   = (r_acc[PROD_W-1:DATA_W] != {DATA_W{1'b0}});
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Multiply state register; reset aborts any operation without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mcand    <= {PROD_W{1'b0}};
      r_acc      <= {PROD_W{1'b0}};
      r_mplier   <= {DATA_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_prod_q   <= {DATA_W{1'b0}};
      r_prod_ovf <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mcand    <= w_mcand_nxt;
      r_acc      <= w_acc_nxt;
      r_mplier   <= w_mplier_nxt;
      r_count    <= w_count_nxt;
      r_prod_q   <= w_prod_nxt;
      r_prod_ovf <= w_ovf_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign busy       = w_busy;
  assign done       = r_done;
  assign carry_flag = r_carry;
  assign zero_flag  = r_zero;
  assign prod_ovf   = r_prod_ovf;
  assign b_out      = w_b_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit.
module tb_alu_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_in;
  logic       load_b_n, sub, eu, sel_prod, flag_en, mul_start;
  logic       busy, done, carry_flag, zero_flag, prod_ovf;
  logic [7:0] b_out;
  logic       tb_drive_en;
  logic [7:0] tb_drive_val;
  wire  [7:0] w_bus;

  int total = 0;
  int bad   = 0;
  int busy_n, done_n, done_k;

  assign w_bus = tb_drive_en ? tb_drive_val : 8'bz;

  alu_unit dut (
    .clk        (clk),
    .reset      (reset),
    .a_in       (a_in),
    .w_bus      (w_bus),
    .load_b_n   (load_b_n),
    .sub        (sub),
    .eu         (eu),
    .sel_prod   (sel_prod),
    .flag_en    (flag_en),
    .mul_start  (mul_start),
    .busy       (busy),
    .done       (done),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .prod_ovf   (prod_ovf),
    .b_out      (b_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load B through the bus with the ALU output disabled.
  task automatic load_b(input logic [7:0] v);
    eu           = 1'b0;
    tb_drive_en  = 1'b1;
    tb_drive_val = v;
    load_b_n     = 1'b0;
    tick();
    load_b_n     = 1'b1;
    tb_drive_en  = 1'b0;
  endtask

  // Start a multiply and observe 15 cycles; optional mid-run disturbances at given cycles.
  task automatic mul_run(input int load_k, input int restart_k, input int chg_a_k,
                         output int b_cnt, output int d_cnt, output int d_at);
    b_cnt = 0;
    d_cnt = 0;
    d_at  = -1;
    eu        = 1'b0;
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (busy === 1'b1) b_cnt++;
      if (done === 1'b1) begin
        d_cnt++;
        d_at = k;
      end
      tb_drive_en  = (k == load_k);
      tb_drive_val = 8'h55;
      load_b_n     = (k == load_k) ? 1'b0 : 1'b1;
      mul_start    = (k == restart_k) ? 1'b1 : 1'b0;
      if (k == chg_a_k) a_in = 8'hFF;
      tick();
    end
    tb_drive_en = 1'b0;
    load_b_n    = 1'b1;
    mul_start   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; a_in = 8'h00; load_b_n = 1'b1; sub = 1'b0; eu = 1'b0;
    sel_prod = 1'b0; flag_en = 1'b0; mul_start = 1'b0;
    tb_drive_en = 1'b0; tb_drive_val = 8'h00;
    tick();
    tick();
    // Reset state, and bus still governed by eu while in reset
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_carry", carry_flag, 1'b0);
    check("rst_zero", zero_flag, 1'b0);
    check("rst_ovf", prod_ovf, 1'b0);
    check("rst_b", b_out, 8'h00);
    eu = 1'b1; sel_prod = 1'b1; #1;
    check("rst_bus_prod", w_bus, 8'h00);
    sel_prod = 1'b0; a_in = 8'h12; #1;
    check("rst_bus_sum", w_bus, 8'h12);
    reset = 1'b0; eu = 1'b0;

    // 5 + 3
    load_b(8'h03);
    check("b_load3", b_out, 8'h03);
    a_in = 8'h05; sub = 1'b0; eu = 1'b1; flag_en = 1'b1; #1;
    check("add_5_3", w_bus, 8'h08);
    tick();
    flag_en = 1'b0;
    check("add_5_3_c", carry_flag, 1'b0);
    check("add_5_3_z", zero_flag, 1'b0);

    // FF + 1 wraps to zero with carry
    load_b(8'h01);
    a_in = 8'hFF; eu = 1'b1; flag_en = 1'b1; #1;
    check("add_ff_1", w_bus, 8'h00);
    tick();
    flag_en = 1'b0;
    check("add_ff_1_c", carry_flag, 1'b1);
    check("add_ff_1_z", zero_flag, 1'b1);

    // flags hold without flag_en; 3 - 5 borrows
    load_b(8'h05);
    check("flag_hold_c", carry_flag, 1'b1);
    check("flag_hold_z", zero_flag, 1'b1);
    a_in = 8'h03; sub = 1'b1; eu = 1'b1; flag_en = 1'b1; #1;
    check("sub_3_5", w_bus, 8'hFE);
    tick();
    check("sub_3_5_c", carry_flag, 1'b0);
    check("sub_3_5_z", zero_flag, 1'b0);

    // 5 - 5: equal operands, no borrow, zero
    a_in = 8'h05; #1;
    check("sub_5_5", w_bus, 8'h00);
    tick();
    flag_en = 1'b0; sub = 1'b0;
    check("sub_5_5_c", carry_flag, 1'b1);
    check("sub_5_5_z", zero_flag, 1'b1);

    // 0x0C * 0x0B = 0x84; a_in changed mid-run must not matter
    load_b(8'h0B);
    a_in = 8'h0C;
    mul_run(-1, -1, 2, busy_n, done_n, done_k);
    check("mul1_busy_cycles", 16'(busy_n), 16'd9);
    check("mul1_done_count", 16'(done_n), 16'd1);
    check("mul1_done_cycle", 16'(done_k), 16'd9);
    eu = 1'b1; sel_prod = 1'b1; #1;
    check("mul1_prod", w_bus, 8'h84);
    check("mul1_ovf", prod_ovf, 1'b0);
    eu = 1'b0; sel_prod = 1'b0;

    // 0x20 * 0x10 = 0x200; second start and a B load during RUN are ignored
    load_b(8'h10);
    a_in = 8'h20;
    mul_run(3, 4, -1, busy_n, done_n, done_k);
    check("mul2_busy_cycles", 16'(busy_n), 16'd9);
    check("mul2_done_count", 16'(done_n), 16'd1);
    check("mul2_b_held", b_out, 8'h10);
    eu = 1'b1; sel_prod = 1'b1; #1;
    check("mul2_prod", w_bus, 8'h00);
    check("mul2_ovf", prod_ovf, 1'b1);
    eu = 1'b0; sel_prod = 1'b0;
    load_b(8'h55);
    check("b_load_after_mul", b_out, 8'h55);

    // 0x04 * 0x55 = 0x154, then add/sub flags while idle
    a_in = 8'h04;
    mul_run(-1, -1, -1, busy_n, done_n, done_k);
    eu = 1'b1; sel_prod = 1'b1; #1;
    check("mul3_prod", w_bus, 8'h54);
    check("mul3_ovf", prod_ovf, 1'b1);
    sel_prod = 1'b0; a_in = 8'hFF; flag_en = 1'b1; #1;
    check("add_ff_55", w_bus, 8'h54);
    tick();
    flag_en = 1'b0; eu = 1'b0;
    check("add_ff_55_c", carry_flag, 1'b1);

    // Reset during RUN cycle 4 aborts with no done pulse
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    done_n = 0;
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1) done_n++;
      tick();
    end
    check("abort_no_done", 16'(done_n), 16'd0);
    check("abort_b", b_out, 8'h00);
    check("abort_carry", carry_flag, 1'b0);
    check("abort_zero", zero_flag, 1'b0);
    check("abort_ovf", prod_ovf, 1'b0);
    eu = 1'b1; sel_prod = 1'b1; #1;
    check("abort_prod", w_bus, 8'h00);
    eu = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
